// File: rtl/vproc_pkg.sv
// rtl/vproc_pkg.sv - shared requester ID type and arbiter defaults
package vproc_pkg;

  localparam int unsigned REQ_ID_W                = 1;
  localparam int unsigned MAX_OUTSTANDING_DEFAULT = 2;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  localparam req_id_t REQ_ID_R0 = 1'b0;
  localparam req_id_t REQ_ID_R1 = 1'b1;

  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/vproc_cache_arb_fifo.sv
// rtl/vproc_cache_arb_fifo.sv - in-order ID FIFO tracking which requester owns each pending response
module vproc_cache_arb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en;
  logic             pop_en;

  // Explicit wrap keeps DEPTH=1 correct, where the pointer has a spare bit.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = push_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/vproc_cache_arbiter.sv
// rtl/vproc_cache_arbiter.sv - two-requester round-robin arbiter onto one cache CPU port
module vproc_cache_arbiter
  import vproc_pkg::*;
#(
  parameter int unsigned ADDR_BIT_W      = 16,
  parameter int unsigned CPU_BYTE_W      = 4,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      r0_req_i,
  input  logic [ADDR_BIT_W-1:0]     r0_addr_i,
  input  logic                      r0_we_i,
  input  logic [CPU_BYTE_W-1:0]     r0_be_i,
  input  logic [CPU_BYTE_W*8-1:0]   r0_wdata_i,
  output logic                      r0_gnt_o,
  output logic                      r0_rvalid_o,
  output logic [CPU_BYTE_W*8-1:0]   r0_rdata_o,
  output logic                      r0_err_o,

  input  logic                      r1_req_i,
  input  logic [ADDR_BIT_W-1:0]     r1_addr_i,
  input  logic                      r1_we_i,
  input  logic [CPU_BYTE_W-1:0]     r1_be_i,
  input  logic [CPU_BYTE_W*8-1:0]   r1_wdata_i,
  output logic                      r1_gnt_o,
  output logic                      r1_rvalid_o,
  output logic [CPU_BYTE_W*8-1:0]   r1_rdata_o,
  output logic                      r1_err_o,

  output logic                      cache_req_o,
  output logic [ADDR_BIT_W-1:0]     cache_addr_o,
  output logic                      cache_we_o,
  output logic [CPU_BYTE_W-1:0]     cache_be_o,
  output logic [CPU_BYTE_W*8-1:0]   cache_wdata_o,
  input  logic                      cache_gnt_i,
  input  logic                      cache_rvalid_i,
  input  logic [CPU_BYTE_W*8-1:0]   cache_rdata_i,
  input  logic                      cache_err_i,

  output logic                      proto_err_o
);

  logic [1:0] req_vec;
  req_id_t    sel;
  req_id_t    prio_q, prio_d;
  req_id_t    lock_id_q, lock_id_d;
  logic       lock_q, lock_d;
  logic       proto_err_q, proto_err_d;
  logic       sel_req;
  logic       grant;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  req_id_t    fifo_head;

  assign req_vec = {r1_req_i, r0_req_i};

  // A held lock only survives while its owner keeps requesting.
  always_comb begin
    sel = REQ_ID_R0;
    if (lock_q && req_vec[lock_id_q]) begin
      sel = lock_id_q;
    end else if (r0_req_i && r1_req_i) begin
      sel = prio_q;
    end else if (r1_req_i) begin
      sel = REQ_ID_R1;
    end
  end

  assign sel_req     = req_vec[sel];
  assign cache_req_o = rst_ni & sel_req & ~fifo_full;
  assign grant       = cache_req_o & cache_gnt_i;

  assign cache_addr_o  = (sel == REQ_ID_R1) ? r1_addr_i  : r0_addr_i;
  assign cache_we_o    = (sel == REQ_ID_R1) ? r1_we_i    : r0_we_i;
  assign cache_be_o    = (sel == REQ_ID_R1) ? r1_be_i    : r0_be_i;
  assign cache_wdata_o = (sel == REQ_ID_R1) ? r1_wdata_i : r0_wdata_i;

  assign r0_gnt_o = grant & (sel == REQ_ID_R0);
  assign r1_gnt_o = grant & (sel == REQ_ID_R1);

  // Responses with nothing pending are swallowed and only flagged.
  assign pop         = rst_ni & cache_rvalid_i & ~fifo_empty;
  assign r0_rvalid_o = pop & (fifo_head == REQ_ID_R0);
  assign r1_rvalid_o = pop & (fifo_head == REQ_ID_R1);

  assign r0_rdata_o = cache_rdata_i;
  assign r1_rdata_o = cache_rdata_i;
  assign r0_err_o   = cache_err_i;
  assign r1_err_o   = cache_err_i;

  assign proto_err_o = rst_ni & proto_err_q;

  always_comb begin
    prio_d      = grant ? other_id(sel) : prio_q;
    lock_d      = cache_req_o & ~cache_gnt_i;
    lock_id_d   = sel;
    proto_err_d = proto_err_q | (cache_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q      <= REQ_ID_R0;
      lock_q      <= 1'b0;
      lock_id_q   <= REQ_ID_R0;
      proto_err_q <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      proto_err_q <= proto_err_d;
    end
  end

  vproc_cache_arb_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (REQ_ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_vproc_cache_arbiter.sv
// tb/tb_vproc_cache_arbiter.sv - self-checking bench for vproc_cache_arbiter
module tb_vproc_cache_arbiter;

  localparam int AW   = 16;
  localparam int BW   = 4;
  localparam int DW   = 32;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          r0_req, r0_we, r0_gnt, r0_rvalid, r0_err;
  logic [AW-1:0] r0_addr;
  logic [BW-1:0] r0_be;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_req, r1_we, r1_gnt, r1_rvalid, r1_err;
  logic [AW-1:0] r1_addr;
  logic [BW-1:0] r1_be;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          c_req, c_we, c_gnt, c_rvalid, c_err;
  logic [AW-1:0] c_addr;
  logic [BW-1:0] c_be;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          proto_err;

  vproc_cache_arbiter #(
    .ADDR_BIT_W(AW), .CPU_BYTE_W(BW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .r0_req_i(r0_req), .r0_addr_i(r0_addr), .r0_we_i(r0_we), .r0_be_i(r0_be),
    .r0_wdata_i(r0_wdata), .r0_gnt_o(r0_gnt), .r0_rvalid_o(r0_rvalid),
    .r0_rdata_o(r0_rdata), .r0_err_o(r0_err),
    .r1_req_i(r1_req), .r1_addr_i(r1_addr), .r1_we_i(r1_we), .r1_be_i(r1_be),
    .r1_wdata_i(r1_wdata), .r1_gnt_o(r1_gnt), .r1_rvalid_o(r1_rvalid),
    .r1_rdata_o(r1_rdata), .r1_err_o(r1_err),
    .cache_req_o(c_req), .cache_addr_o(c_addr), .cache_we_o(c_we), .cache_be_o(c_be),
    .cache_wdata_o(c_wdata), .cache_gnt_i(c_gnt), .cache_rvalid_i(c_rvalid),
    .cache_rdata_i(c_rdata), .cache_err_i(c_err),
    .proto_err_o(proto_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: pending owners in issue order, plus round-robin/lock state.
  int q[$];
  int m_prio, m_lock, m_lock_id, m_proto;
  int e_sel;
  bit e_creq, e_g0, e_g1, e_pop, e_rv0, e_rv1, e_proto;
  bit cur_rst, cur_gnt, cur_rv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input bit rst, input bit q0, input logic [AW-1:0] a0, input bit w0,
                       input bit q1, input logic [AW-1:0] a1, input bit w1,
                       input bit gnt, input bit rv, input logic [DW-1:0] rd, input bit er);
    bit sreq;
    rst_n = rst; r0_req = q0; r0_addr = a0; r0_we = w0;
    r1_req = q1; r1_addr = a1; r1_we = w1;
    r0_be = BW'($urandom); r1_be = BW'($urandom);
    r0_wdata = $urandom; r1_wdata = $urandom;
    c_gnt = gnt; c_rvalid = rv; c_rdata = rd; c_err = er;
    cur_rst = rst; cur_gnt = gnt; cur_rv = rv;
    e_sel = 0; e_creq = 0; e_g0 = 0; e_g1 = 0; e_pop = 0; e_rv0 = 0; e_rv1 = 0;
    if (rst) begin
      if (m_lock != 0 && ((m_lock_id == 0) ? q0 : q1)) e_sel = m_lock_id;
      else if (q0 && q1) e_sel = m_prio;
      else if (q1) e_sel = 1;
      else e_sel = 0;
      sreq   = (e_sel == 0) ? q0 : q1;
      e_creq = sreq && (q.size() < MAXO);
      e_g0   = gnt && e_creq && (e_sel == 0);
      e_g1   = gnt && e_creq && (e_sel == 1);
      e_pop  = rv && (q.size() > 0);
      e_rv0  = e_pop && (q[0] == 0);
      e_rv1  = e_pop && (q[0] == 1);
    end
    e_proto = rst && (m_proto != 0);
    #1;
    chk("cache_req", c_req, e_creq);
    chk("r0_gnt", r0_gnt, e_g0);
    chk("r1_gnt", r1_gnt, e_g1);
    chk("r0_rvalid", r0_rvalid, e_rv0);
    chk("r1_rvalid", r1_rvalid, e_rv1);
    chk("proto_err", proto_err, e_proto);
    chk("r0_rdata", r0_rdata, rd);
    chk("r1_rdata", r1_rdata, rd);
    chk("r0_err", r0_err, er);
    chk("r1_err", r1_err, er);
    if (e_creq) begin
      chk("cache_addr", c_addr, (e_sel == 1) ? a1 : a0);
      chk("cache_we", c_we, (e_sel == 1) ? w1 : w0);
      chk("cache_be", c_be, (e_sel == 1) ? r1_be : r0_be);
      chk("cache_wdata", c_wdata, (e_sel == 1) ? r1_wdata : r0_wdata);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!cur_rst) begin
      q.delete(); m_prio = 0; m_lock = 0; m_lock_id = 0; m_proto = 0;
    end else begin
      if (cur_rv && q.size() == 0) m_proto = 1;
      if (e_pop) void'(q.pop_front());
      if (e_g0 || e_g1) begin
        q.push_back(e_sel);
        m_prio = 1 - e_sel;
      end
      m_lock    = (e_creq && !cur_gnt) ? 1 : 0;
      m_lock_id = e_sel;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rst, input bit rv);
    apply(rst, 0, '0, 0, 0, '0, 0, 0, rv, DW'($urandom), 0);
  endtask

  initial begin
    m_prio = 0; m_lock = 0; m_lock_id = 0; m_proto = 0;
    rst_n = 0; r0_req = 0; r1_req = 0; c_gnt = 0; c_rvalid = 0;
    @(negedge clk);

    // Reset with everything asserted: all outputs must stay low.
    apply(0, 1, 16'h0100, 0, 1, 16'h0200, 1, 1, 1, 32'h1, 0);
    chk("rst_cache_req", c_req, 0);
    tick();
    idle(0, 0); tick();

    // Single requester read.
    apply(1, 1, 16'h1000, 0, 0, '0, 0, 1, 0, 32'h0, 0);
    chk("s_gnt0", r0_gnt, 1);
    chk("s_addr", c_addr, 16'h1000);
    tick();
    apply(1, 0, '0, 0, 0, '0, 0, 0, 1, 32'hDEADBEEF, 0);
    chk("s_rvalid0", r0_rvalid, 1);
    chk("s_rdata0", r0_rdata, 32'hDEADBEEF);
    chk("s_rvalid1", r1_rvalid, 0);
    tick();

    // Contention: grants alternate from r0, responses follow grant order.
    idle(0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      apply(1, 1, AW'(16'h2000 + i), 0, 1, AW'(16'h3000 + i), 1, 1, (i > 0), DW'(i), 0);
      chk("rr_gnt0", r0_gnt, (i % 2) == 0);
      chk("rr_gnt1", r1_gnt, (i % 2) == 1);
      if (i > 0) chk("rr_rv0", r0_rvalid, ((i - 1) % 2) == 0);
      tick();
    end
    idle(1, 1);
    chk("rr_drain_rv1", r1_rvalid, 1);
    tick();

    // Stall lock, then fill to MAX_OUTSTANDING and release one slot.
    idle(0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 16'h4000, 0, 1, 16'h5000, 0, 0, 0, 32'h0, 0);
      chk("lk_addr", c_addr, 16'h4000);
      tick();
    end
    apply(1, 1, 16'h4000, 0, 1, 16'h5000, 0, 1, 0, 32'h0, 0);
    chk("lk_gnt0", r0_gnt, 1);
    tick();
    apply(1, 1, 16'h4004, 0, 1, 16'h5000, 0, 1, 0, 32'h0, 0);
    chk("lk_gnt1", r1_gnt, 1);
    tick();
    apply(1, 1, 16'h4008, 0, 1, 16'h5004, 0, 1, 0, 32'h0, 0);
    chk("full_req", c_req, 0);
    tick();
    apply(1, 1, 16'h4008, 0, 1, 16'h5004, 0, 1, 1, 32'hA5A5, 0);
    chk("full_nobypass", c_req, 0);
    chk("full_rv0", r0_rvalid, 1);
    tick();
    apply(1, 1, 16'h4008, 0, 1, 16'h5004, 0, 0, 0, 32'h0, 0);
    chk("full_reopen", c_req, 1);
    tick();
    idle(1, 1);
    chk("full_rv1", r1_rvalid, 1);
    tick();

    // Protocol error is sticky until reset.
    idle(1, 1);
    chk("pe_rv0", r0_rvalid, 0);
    chk("pe_rv1", r1_rvalid, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(1, 0);
      chk("pe_sticky", proto_err, 1);
      tick();
    end
    apply(0, 1, 16'h0, 0, 1, 16'h0, 0, 1, 1, 32'h0, 0);
    chk("pe_in_rst", proto_err, 0);
    tick();
    idle(1, 0); tick();

    // Reset mid-flight discards the outstanding ID.
    apply(1, 0, '0, 0, 1, 16'h6000, 1, 1, 0, 32'h0, 0);
    chk("mf_gnt1", r1_gnt, 1);
    tick();
    idle(0, 0); tick();
    idle(1, 1);
    chk("mf_rv1", r1_rvalid, 0);
    tick();
    idle(1, 0);
    chk("mf_proto", proto_err, 1);
    tick();
    idle(0, 0); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bit rs, q0, q1, w0, w1, g, rv, er;
      rs = ($urandom_range(0, 79) != 0);
      q0 = 1'($urandom_range(0, 1));
      q1 = 1'($urandom_range(0, 1));
      w0 = 1'($urandom_range(0, 1));
      w1 = 1'($urandom_range(0, 1));
      g  = ($urandom_range(0, 3) != 0);
      rv = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) == 0);
      er = ($urandom_range(0, 7) == 0);
      apply(rs, q0, AW'($urandom), w0, q1, AW'($urandom), w1, g, rv, DW'($urandom), er);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vproc_cache_arbiter.md
VPROC_CACHE_ARBITER -- requirements
Module: vproc_cache_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_BIT_W, default 16, address width in bits; CPU_BYTE_W, default 4, data width in bytes; MAX_OUTSTANDING, default 2, in-flight response limit (power of 2, ≥1).
REQ-002 Clocking SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-003 clk_i  in  1  clock.
REQ-004 rst_ni  in  1  synchronous active-low reset.
REQ-005 rN_req_i  in  1  request from requester N (N = 0, 1).
REQ-006 rN_addr_i  in  ADDR_BIT_W  address.
REQ-007 rN_we_i  in  1  write enable.
REQ-008 rN_be_i  in  CPU_BYTE_W  byte enable.
REQ-009 rN_wdata_i  in  CPU_BYTE_W*8  write data.
REQ-010 rN_gnt_o  out  1  grant.
REQ-011 rN_rvalid_o  out  1  response valid.
REQ-012 rN_rdata_o  out  CPU_BYTE_W*8  read data.
REQ-013 rN_err_o  out  1  response error.
REQ-014 cache_req_o, cache_addr_o, cache_we_o, cache_be_o, cache_wdata_o  out  1/ADDR_BIT_W/1/CPU_BYTE_W/CPU_BYTE_W*8  request to the cache CPU port.
REQ-015 cache_gnt_i, cache_rvalid_i, cache_rdata_i, cache_err_i  in  1/1/CPU_BYTE_W*8/1  cache response.
REQ-016 proto_err_o  out  1  sticky flag: rvalid received with no response outstanding.

Function
REQ-017 The block SHALL select at most one requester per cycle and forward that requester's addr/we/be/wdata combinationally to cache_*.
REQ-018 cache_req_o SHALL be 1 only when the selected requester's req is 1 and the outstanding count < MAX_OUTSTANDING.
REQ-019 rN_gnt_o SHALL equal cache_gnt_i & cache_req_o & (selected == N), and the non-selected requester's gnt SHALL be 0.
REQ-020 Arbitration SHALL be round-robin: when both requesters request and no lock is held, the requester indicated by prio_q SHALL win; on a grant to N, prio_q SHALL be set to the other requester.
REQ-021 When only one requester requests, it SHALL be selected regardless of prio_q.
REQ-022 Lock rule: when cache_req_o=1 and cache_gnt_i=0, the selection SHALL be held in the next cycle (lock_q), so that a presented request is never withdrawn in favour of the other requester; lock_q SHALL clear on grant.
REQ-023 If the locked requester drops req, lock_q SHALL clear and arbitration SHALL resume in that same cycle.
REQ-024 On each cache grant, the granted ID SHALL be pushed into an in-order ID FIFO of depth MAX_OUTSTANDING, and the outstanding count SHALL increment.
REQ-025 On cache_rvalid_i, the FIFO head ID SHALL be popped: rHEAD_rvalid_o=1 and rHEAD_rdata_o/err_o=cache_rdata_i/err_i, while the other requester's rvalid SHALL be 0.
REQ-026 rdata_o/err_o SHALL be driven to both requesters at all times and qualified only by rvalid.
REQ-027 A push and a pop in the same cycle SHALL leave the count unchanged, with the FIFO ordering preserved.
REQ-028 When the count equals MAX_OUTSTANDING, cache_req_o SHALL be 0 in that cycle even if a pop occurs in the same cycle (no full-bypass).
REQ-029 A cache_rvalid_i with an empty FIFO SHALL be dropped (no rvalid to either requester) and SHALL set proto_err_o, which stays 1 until reset.
REQ-030 Write requests SHALL be tracked identically to reads, because the cache returns rvalid for writes.
REQ-031 The count and FIFO pointers SHALL wrap modulo MAX_OUTSTANDING and SHALL use a $clog2(MAX_OUTSTANDING)+1-bit counter.

Reset
REQ-032 While rst_ni=0, all outputs SHALL be 0: cache_req_o, all gnt/rvalid, and proto_err_o.
REQ-033 After the clock edge with rst_ni=0, the state SHALL be: prio_q=0, lock_q=0, count=0, FIFO pointers=0, proto_err=0.
REQ-034 Reset asserted mid-transaction SHALL discard all outstanding IDs, and responses arriving after reset releases SHALL be treated per REQ-029.

Structure
REQ-035 The requester ID typedef (1-bit, REQ_ID_W) and the MAX_OUTSTANDING default SHALL live in the shared vproc_pkg.
REQ-036 The ID FIFO SHALL be one sub-module, vproc_cache_arb_fifo (parameters DEPTH and WIDTH; push/pop/full/empty/head), and the remaining logic SHALL be in the top level.

Verification
REQ-037 Single requester: r0 read at 0x1000, gnt in cycle 0, cache rvalid in cycle 1 with rdata 0xDEADBEEF -> r0_rvalid_o=1 with rdata 0xDEADBEEF in cycle 1, and r1_rvalid_o=0.
REQ-038 Contention: both requesters request continuously, gnt always 1 -> grants alternate r0, r1, r0, r1 starting with r0 after reset, and responses route in grant order.
REQ-039 Stall lock: r0 and r1 request, cache_gnt_i=0 for 3 cycles -> cache_addr_o stays at r0's address for all 3 cycles; on gnt, r0 is granted and r1 wins the next cycle.
REQ-040 Full: MAX_OUTSTANDING=2, two grants with no rvalid -> cache_req_o=0 in the next cycle; one rvalid -> cache_req_o=1 in the following cycle, not in the same cycle.
REQ-041 Protocol error: cache_rvalid_i=1 with an empty FIFO -> no requester rvalid, proto_err_o=1 from the next cycle until rst_ni=0.
REQ-042 Reset mid-flight: one response outstanding, rst_ni=0 for one cycle -> count=0, and a later rvalid sets proto_err_o.
